// File: rtl/rf_pkg.sv
// Shared types and constants for the 8x16 register-file write-port controller.
package rf_pkg;

    localparam int RF_WIDTH = 16;
    localparam int RF_AW    = 3;
    localparam int RF_NREGS = 1 << RF_AW;

    typedef enum logic {
        IDLE  = 1'b0,
        CLEAR = 1'b1
    } state_t;

    typedef enum logic {
        REQ_A = 1'b0,
        REQ_B = 1'b1
    } req_id_t;

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin grant with a registered priority pointer.
// The pointer moves to the losing side after every grant; block suppresses all grants.
module rr_arb2
    import rf_pkg::*;
(
    input  logic clk,
    input  logic reset,
    input  logic a_valid,
    input  logic b_valid,
    input  logic block,
    output logic a_grant,
    output logic b_grant
);

    req_id_t pri_reg;
    req_id_t pri_next;

    always_comb begin
        a_grant  = 1'b0;
        b_grant  = 1'b0;
        pri_next = pri_reg;
        if (!block) begin
            if (a_valid && (!b_valid || pri_reg == REQ_A)) begin
                a_grant = 1'b1;
            end else if (b_valid) begin
                b_grant = 1'b1;
            end
        end
        // A grant always implies a transfer, since grants require valid.
        if (a_grant) begin
            pri_next = REQ_B;
        end else if (b_grant) begin
            pri_next = REQ_A;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pri_reg <= REQ_A;
        end else begin
            pri_reg <= pri_next;
        end
    end

endmodule

// File: rtl/rf_wr_arb.sv
// Write-port controller: round-robin between requesters A and B, plus a clear-all
// sequence that writes zero to every register. All register-file outputs are registered.
module rf_wr_arb
    import rf_pkg::*;
#(
    parameter int WIDTH = RF_WIDTH,
    parameter int AW    = RF_AW
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             a_valid,
    input  logic [AW-1:0]    a_addr,
    input  logic [WIDTH-1:0] a_data,
    output logic             a_ready,
    input  logic             b_valid,
    input  logic [AW-1:0]    b_addr,
    input  logic [WIDTH-1:0] b_data,
    output logic             b_ready,
    input  logic             clr_req,
    output logic             clr_busy,
    output logic             clr_done,
    output logic             rf_wr,
    output logic [AW-1:0]    rf_wr_addr,
    output logic [WIDTH-1:0] rf_d_in
);

    localparam logic [AW:0] CNT_ONE = {{AW{1'b0}}, 1'b1};

    state_t           state_reg, state_next;
    logic [AW:0]      cnt_reg, cnt_next;
    logic             wr_reg, wr_next;
    logic [AW-1:0]    addr_reg, addr_next;
    logic [WIDTH-1:0] data_reg, data_next;
    logic             done_reg, done_next;

    logic a_grant;
    logic b_grant;
    logic block;

    // A clear request wins over both requesters in the cycle it is seen.
    assign block = (state_reg == CLEAR) || clr_req;

    rr_arb2 u_arb (
        .clk     (clk),
        .reset   (reset),
        .a_valid (a_valid),
        .b_valid (b_valid),
        .block   (block),
        .a_grant (a_grant),
        .b_grant (b_grant)
    );

    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        wr_next    = 1'b0;
        addr_next  = addr_reg;
        data_next  = data_reg;
        done_next  = 1'b0;
        case (state_reg)
            IDLE: begin
                if (clr_req) begin
                    state_next = CLEAR;
                    wr_next    = 1'b1;
                    addr_next  = '0;
                    data_next  = '0;
                    cnt_next   = CNT_ONE;
                end else if (a_grant) begin
                    wr_next   = 1'b1;
                    addr_next = a_addr;
                    data_next = a_data;
                end else if (b_grant) begin
                    wr_next   = 1'b1;
                    addr_next = b_addr;
                    data_next = b_data;
                end
            end
            CLEAR: begin
                // The extra counter bit sets only once the last address has been issued.
                if (cnt_reg[AW]) begin
                    state_next = IDLE;
                    done_next  = 1'b1;
                    cnt_next   = '0;
                end else begin
                    wr_next   = 1'b1;
                    addr_next = cnt_reg[AW-1:0];
                    data_next = '0;
                    cnt_next  = cnt_reg + CNT_ONE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg <= IDLE;
            cnt_reg   <= '0;
            wr_reg    <= 1'b0;
            addr_reg  <= '0;
            data_reg  <= '0;
            done_reg  <= 1'b0;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
            wr_reg    <= wr_next;
            addr_reg  <= addr_next;
            data_reg  <= data_next;
            done_reg  <= done_next;
        end
    end

    assign a_ready    = a_grant;
    assign b_ready    = b_grant;
    assign clr_busy   = (state_reg == CLEAR);
    assign clr_done   = done_reg;
    assign rf_wr      = wr_reg;
    assign rf_wr_addr = addr_reg;
    assign rf_d_in    = data_reg;

endmodule

// File: doc/rf_wr_arb.md
# rf_wr_arb

Write-port controller for the 8×16 register file. It shares the file's single write port between two requesters, A and B, using round-robin arbitration with a valid/ready handshake. It also runs a clear sequence that writes zero to all eight registers. Its registered outputs drive the register file's `wr`, `wr_addr` and `d_in` inputs directly; the read ports are not touched.

## Interface
Parameters:
- `WIDTH`, 16, data width of one register.
- `AW`, 3, register address width; register count is 2^AW = 8.

Ports:
- `clk`  in  1  single clock; all state updates on its rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `a_valid`  in  1  requester A has a write pending.
- `a_addr`  in  AW  requester A target register.
- `a_data`  in  WIDTH  requester A write data.
- `a_ready`  out  1  A is granted this cycle (combinational).
- `b_valid`, `b_addr`, `b_data`, `b_ready`: same as A, for requester B.
- `clr_req`  in  1  start a clear-all sequence.
- `clr_busy`  out  1  clear sequence in progress (registered).
- `clr_done`  out  1  one-cycle pulse after the last clear write (registered).
- `rf_wr`  out  1  to reg_file `wr` (registered).
- `rf_wr_addr`  out  AW  to reg_file `wr_addr` (registered).
- `rf_d_in`  out  WIDTH  to reg_file `d_in` (registered).

## Operation
- Two states: IDLE (arbitrate) and CLEAR (walk registers 0..7). Reset enters IDLE.
- **Arbitration in IDLE with `clr_req` = 0:**
  - If only one requester is valid, it is granted.
  - If both are valid, the requester named by the priority pointer `pri` is granted (0 = A, 1 = B).
  - The grant is combinational: `a_ready` = grant_A, `b_ready` = grant_B. Both readies are 0 if neither is valid.
  - A transfer occurs when valid & ready.
  - At the edge of a transfer, `pri` moves to the loser (granted A → `pri` = B, and vice versa). With no transfer, `pri` holds.
- **Write output:**
  - On a transfer edge: `rf_wr`←1, `rf_wr_addr`←granted addr, `rf_d_in`←granted data.
  - Otherwise `rf_wr`←0, and `rf_wr_addr`/`rf_d_in` hold their values.
- **Starting a clear:**
  - `clr_req` = 1 in IDLE takes priority: both readies are 0 in that cycle and no grant is made.
  - At that edge: state←CLEAR, `rf_wr`←1, `rf_wr_addr`←0, `rf_d_in`←0, `cnt`←1.
- **In CLEAR:**
  - Each edge: `rf_wr_addr`←`cnt`, `cnt`←`cnt`+1.
  - After the edge that issues address 7, the next edge sets state←IDLE, `rf_wr`←0, `clr_done`←1.
  - Readies are 0 throughout CLEAR. `clr_req` is ignored during CLEAR. `pri` is unchanged by a clear.
- `clr_busy` = (state == CLEAR). `clr_done` is high for exactly one cycle and is 0 otherwise.
- Addresses are unsigned AW-bit values. The clear counter is AW+1 bits so that 7 can be detected without wrap; addresses never wrap inside one sequence.

## Timing
- **Reset values:** state IDLE, `pri` = A, `cnt` = 0, `rf_wr` = 0, `rf_wr_addr` = 0, `rf_d_in` = 0, `clr_busy` = 0, `clr_done` = 0. `a_ready`/`b_ready` follow the IDLE grant logic.
- **Reset mid-operation:** reset asserted during CLEAR or during a transfer cycle aborts immediately. The partial clear is not resumed and `clr_done` is not pulsed.
- **Write latency:**
  - Transfer at edge E → `rf_wr` high during cycle E..E+1.
  - The register file captures the data at edge E+1; read ports show the new value after E+1.
- **Clear latency:**
  - `clr_req` sampled at edge E0 → `rf_wr` high for exactly 8 cycles with addresses 0,1,…,7.
  - `clr_busy` is high over the same 8 cycles.
  - `clr_done` is high in the 9th cycle after E0.
  - An IDLE grant is possible again in that same 9th cycle.
- **Back-to-back:** a continuously valid requester gets one transfer per cycle. With both continuously valid, grants alternate A, B, A, B.
- **Handshake:** requesters must hold addr/data stable while valid and not ready. Dropping valid before ready is permitted and produces no write.

## Structure
- Package `rf_pkg`:
  - constants `RF_WIDTH` = 16, `RF_AW` = 3, `RF_NREGS` = 8;
  - state typedef {IDLE, CLEAR};
  - requester-id typedef {REQ_A, REQ_B}.
- One sub-module `rr_arb2`: combinational 2-way grant from (`a_valid`, `b_valid`, `pri`, `block`) plus the `pri` update register.
- The top level holds the FSM, the clear counter and the output registers. Integration instantiates `reg_file` alongside; the block does not contain it.

## Test plan
- **Reset:** assert reset mid-cycle → all outputs at the reset values immediately; release → `a_valid` = 1, `a_addr` = 3, `a_data` = 16'h1234 gives `a_ready` = 1, then `rf_wr` = 1, `rf_wr_addr` = 3, `rf_d_in` = 16'h1234 for one cycle; reg 3 reads 16'h1234.
- **Round-robin:** A and B both valid for 4 cycles (A→reg1 16'hAAAA, B→reg2 16'hBBBB) → grant order A, B, A, B; `rf_wr_addr` sequence 1, 2, 1, 2.
- **Single requester:** only B valid with `pri` = A → B granted every cycle; `pri` ends as A.
- **Clear:** preload all registers with 16'hFFFF, pulse `clr_req` → 8 consecutive writes, addresses 0..7, data 0; `clr_busy` high 8 cycles; `clr_done` pulse in cycle 9; all registers read 0.
- **Clear collision:** `clr_req` = 1 while A is valid → `a_ready` = 0 for all of CLEAR; A's write to reg5 (16'h00C3) is performed in the `clr_done` cycle, so reg5 = 16'h00C3 afterwards.
- **Reset during CLEAR:** assert reset after address 4 is issued → no `clr_done` pulse; regs 0..3 (or 0..4) are zero and the rest are unchanged; IDLE after release.
